// File: rtl/tdm_mux8.sv
// tdm_mux8: snapshots eight channels and serializes them one slot at a time onto d0 with a 3-bit select
module tdm_mux8 #(
  parameter int HOLD_CYCLES = 1,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] ch_in,
  output logic       d0,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       valid,
  output logic       frame_start,
  output logic       busy,
  output logic       done
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t        r_state;
  logic [7:0]    r_snap;
  logic [2:0]    r_slot;
  logic [HW-1:0] r_hold;
  logic          w_last_hold;
  logic [2:0]    w_nslot;
  assign w_last_hold = r_hold == HW'(HOLD_CYCLES - 1);
  assign w_nslot     = r_slot + 3'd1;
  // Pulses only fire on enabled edges, so a frozen cycle naturally defers them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_snap <= '0;
      r_slot <= '0;
      r_hold <= '0;
      {d0, s0, s1, s2, valid, frame_start, busy, done} <= '0;
    end else if (!enable) begin
      valid <= 1'b0;
      frame_start <= 1'b0;
      done <= 1'b0;
    end else if (r_state == IDLE) begin
      frame_start <= 1'b0;
      done <= 1'b0;
      if (start) begin
        r_state <= SEND;
        r_snap <= ch_in;
        r_slot <= '0;
        r_hold <= '0;
        {s0, s1, s2} <= 3'd0;
        d0 <= ch_in[0];
        valid <= 1'b1;
        busy <= 1'b1;
        frame_start <= 1'b1;
      end
    end else if (!w_last_hold) begin
      r_hold <= r_hold + 1'b1;
      valid <= 1'b1;
      frame_start <= 1'b0;
      done <= 1'b0;
    end else if (r_slot != 3'd7) begin
      r_hold <= '0;
      r_slot <= w_nslot;
      {s0, s1, s2} <= w_nslot;
      d0 <= r_snap[w_nslot];
      valid <= 1'b1;
      frame_start <= 1'b0;
      done <= 1'b0;
    end else if (CONTINUOUS) begin
      r_hold <= '0;
      r_slot <= '0;
      r_snap <= ch_in;
      {s0, s1, s2} <= 3'd0;
      d0 <= ch_in[0];
      valid <= 1'b1;
      frame_start <= 1'b1;
      done <= 1'b1;
    end else begin
      r_hold <= '0;
      r_state <= IDLE;
      valid <= 1'b0;
      busy <= 1'b0;
      frame_start <= 1'b0;
      done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tdm_mux8.sv
// tb_tdm_mux8: directed checks of tdm_mux8 across hold, continuous and pause configurations
module tb_tdm_mux8;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b1, start = 1'b0;
  logic [7:0] ch = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  logic a_d0, a_s0, a_s1, a_s2, a_v, a_fs, a_b, a_dn;
  logic b_d0, b_s0, b_s1, b_s2, b_v, b_fs, b_b, b_dn;
  logic c_d0, c_s0, c_s1, c_s2, c_v, c_fs, c_b, c_dn;
  wire [7:0] a_pk = {a_s0, a_s1, a_s2, a_d0, a_v, a_fs, a_b, a_dn};
  wire [7:0] b_pk = {b_s0, b_s1, b_s2, b_d0, b_v, b_fs, b_b, b_dn};
  wire [7:0] c_pk = {c_s0, c_s1, c_s2, c_d0, c_v, c_fs, c_b, c_dn};
  tdm_mux8 #(.HOLD_CYCLES(1), .CONTINUOUS(1'b0)) u_a (.clock(clk), .reset(rst), .enable(en), .start(start), .ch_in(ch),
    .d0(a_d0), .s0(a_s0), .s1(a_s1), .s2(a_s2), .valid(a_v), .frame_start(a_fs), .busy(a_b), .done(a_dn));
  tdm_mux8 #(.HOLD_CYCLES(3), .CONTINUOUS(1'b0)) u_b (.clock(clk), .reset(rst), .enable(en), .start(start), .ch_in(ch),
    .d0(b_d0), .s0(b_s0), .s1(b_s1), .s2(b_s2), .valid(b_v), .frame_start(b_fs), .busy(b_b), .done(b_dn));
  tdm_mux8 #(.HOLD_CYCLES(1), .CONTINUOUS(1'b1)) u_c (.clock(clk), .reset(rst), .enable(en), .start(start), .ch_in(ch),
    .d0(c_d0), .s0(c_s0), .s1(c_s1), .s2(c_s2), .valid(c_v), .frame_start(c_fs), .busy(c_b), .done(c_dn));
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] ex(input logic [2:0] k, input logic d, input logic v, input logic f, input logic b, input logic n);
    return {k, d, v, f, b, n};
  endfunction
  task do_reset;
    rst = 1'b1;
    start = 1'b0;
    en = 1'b1;
    tick;
    rst = 1'b0;
  endtask
  task run_a(input logic [7:0] c);
    logic [7:0] lb;
    lb = '0;
    ch = c;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick;
      check("a_slot", a_pk, ex(3'(k), c[k], 1'b1, k == 0, 1'b1, 1'b0));
      lb[{a_s0, a_s1, a_s2}] = a_d0;
    end
    tick;
    check("a_done", a_pk, ex(3'd7, c[7], 1'b0, 1'b0, 1'b0, 1'b1));
    check("a_loopback", lb, c);
    tick;
    check("a_idle", a_pk, ex(3'd7, c[7], 1'b0, 1'b0, 1'b0, 1'b0));
  endtask
  task run_b(input logic [7:0] c, input int p);
    int m;
    ch = c;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int n = 1; n <= 25 + p; n++) begin
      if (n > 1) begin
        en = !(n >= 11 && n <= 10 + p);
        tick;
      end
      m = n > 10 + p ? n - p : n;
      if (n >= 11 && n <= 10 + p)
        check("b_pause", b_pk, ex(3'd3, c[3], 1'b0, 1'b0, 1'b1, 1'b0));
      else if (n == 25 + p)
        check("b_done", b_pk, ex(3'd7, c[7], 1'b0, 1'b0, 1'b0, 1'b1));
      else
        check("b_slot", b_pk, ex(3'((m - 1) / 3), c[(m - 1) / 3], 1'b1, m == 1, 1'b1, 1'b0));
    end
    en = 1'b1;
  endtask
  initial begin
    logic [7:0] s, f1, f2;
    int dn;
    do_reset;
    check("a_reset", a_pk, 8'h00);
    check("b_reset", b_pk, 8'h00);
    check("c_reset", c_pk, 8'h00);
    run_a(8'b1010_0110);
    do_reset;
    en = 1'b0;
    start = 1'b1;
    tick;
    en = 1'b1;
    start = 1'b0;
    tick;
    check("a_start_disabled", a_pk, 8'h00);
    do_reset;
    run_b(8'hFF, 0);
    do_reset;
    run_b(8'h5A, 4);
    do_reset;
    s = 8'h3C;
    ch = s;
    start = 1'b1;
    tick;
    start = 1'b0;
    dn = 0;
    check("a_snap", a_pk, ex(3'd0, s[0], 1'b1, 1'b1, 1'b1, 1'b0));
    for (int k = 1; k < 8; k++) begin
      ch = 8'($urandom);
      start = k == 3;
      tick;
      check("a_snap", a_pk, ex(3'(k), s[k], 1'b1, 1'b0, 1'b1, 1'b0));
      dn += int'(a_dn);
    end
    start = 1'b0;
    tick;
    check("a_snap_done", a_pk, ex(3'd7, s[7], 1'b0, 1'b0, 1'b0, 1'b1));
    dn += int'(a_dn);
    tick;
    dn += int'(a_dn);
    check("a_done_count", dn, 1);
    do_reset;
    f1 = 8'h0F;
    f2 = 8'hF0;
    ch = f1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick;
      check("c_frame1", c_pk, ex(3'(k), f1[k], 1'b1, k == 0, 1'b1, 1'b0));
    end
    ch = f2;
    tick;
    check("c_wrap", c_pk, ex(3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    for (int k = 1; k < 8; k++) begin
      tick;
      check("c_frame2", c_pk, ex(3'(k), f2[k], 1'b1, 1'b0, 1'b1, 1'b0));
    end
    do_reset;
    ch = 8'hA6;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick;
    check("a_slot5", a_pk, ex(3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    rst = 1'b1;
    tick;
    check("a_mid_reset", a_pk, 8'h00);
    rst = 1'b0;
    tick;
    check("a_post_reset", a_pk, 8'h00);
    run_a(8'h81);
    do_reset;
    ch = 8'hA6;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick;
    check("a_done_b2b", a_pk, ex(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    ch = 8'h55;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("a_restart", a_pk, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
